// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache dirty-bit store and its flush engine.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } flush_state_t;

  function automatic int set_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int way_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

  function automatic int cnt_w(input int num_sets, input int num_ways);
    return $clog2(num_sets * num_ways + 1);
  endfunction

  // Linear line index is {set, way}: way varies fastest.
  function automatic int line_set(input int line, input int ways_w);
    return line >> ways_w;
  endfunction

  function automatic int line_way(input int line, input int ways_w);
    return line & ((1 << ways_w) - 1);
  endfunction

endpackage

// File: rtl/dirty_array_flush_if.sv
// Controller-facing bundle for the dirty array: indexed write/read, flush control,
// write-back request handshake and dirty line count.
interface dirty_array_flush_if #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4
);
  localparam int SET_W = cache_pkg::set_w(NUM_SETS);
  localparam int WAY_W = cache_pkg::way_w(NUM_WAYS);
  localparam int CNT_W = cache_pkg::cnt_w(NUM_SETS, NUM_WAYS);

  logic [SET_W-1:0]    set_idx;
  logic [WAY_W-1:0]    way_idx;
  logic                dirty_we;
  logic                miss;
  logic                dirty_d;
  logic [NUM_WAYS-1:0] dirty_q;
  logic                flush_req;
  logic                flush_busy;
  logic                flush_done;
  logic                wb_valid;
  logic [SET_W-1:0]    wb_set;
  logic [WAY_W-1:0]    wb_way;
  logic                wb_ready;
  logic [CNT_W-1:0]    dirty_count;

  modport master (
    output set_idx, way_idx, dirty_we, miss, dirty_d, flush_req, wb_ready,
    input  dirty_q, flush_busy, flush_done, wb_valid, wb_set, wb_way, dirty_count
  );

  modport slave (
    input  set_idx, way_idx, dirty_we, miss, dirty_d, flush_req, wb_ready,
    output dirty_q, flush_busy, flush_done, wb_valid, wb_set, wb_way, dirty_count
  );

endinterface

// File: rtl/dirty_flush_scan.sv
// Flush engine: walks every line once, raises a write-back request per dirty line.
// Latency: one line examined per cycle; empty array finishes NUM_SETS*NUM_WAYS+1 cycles after flush_req.
// Backpressure: wb_valid/wb_set/wb_way hold and the pointer stalls until wb_ready.
module dirty_flush_scan
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4,
  localparam int SET_W = set_w(NUM_SETS),
  localparam int WAY_W = way_w(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_req,
  input  logic             line_dirty,
  input  logic             wb_ready,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_valid,
  output logic             clr_stb,
  output logic [SET_W-1:0] ptr_set,
  output logic [WAY_W-1:0] ptr_way
);
  localparam int LINE_W = SET_W + WAY_W;
  localparam int LAST   = NUM_SETS * NUM_WAYS - 1;

  flush_state_t      state;
  logic [LINE_W-1:0] ptr;
  logic              at_last;

  assign at_last = (ptr == LINE_W'(LAST));
  assign clr_stb = wb_valid & wb_ready;
  assign ptr_set = SET_W'(line_set(int'(ptr), WAY_W));
  assign ptr_way = WAY_W'(line_way(int'(ptr), WAY_W));

  // Outputs are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      wb_valid   <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            ptr        <= '0;
            state      <= SCAN;
            flush_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (line_dirty) begin
            state    <= WB;
            wb_valid <= 1'b1;
          end else if (at_last) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end else begin
            ptr <= ptr + LINE_W'(1);
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (at_last) begin
              state      <= DONE;
              flush_done <= 1'b1;
            end else begin
              ptr   <= ptr + LINE_W'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
          wb_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dirty_array_flush.sv
// Dirty-bit array for a NUM_SETS x NUM_WAYS cache with a flush/write-back engine; DIRTY_COUNT_EN adds a dirty line counter.
// Latency: writes land at the next edge, dirty_q reads registered state combinationally.
// Backpressure: flush stalls on wb_ready; controller writes are always accepted and win over a write-back clear.
module dirty_array_flush
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4
) (
  input logic               clk,
  input logic               reset,
  dirty_array_flush_if.slave bus
);
  localparam int SET_W = set_w(NUM_SETS);
  localparam int WAY_W = way_w(NUM_WAYS);
  localparam int CNT_W = cnt_w(NUM_SETS, NUM_WAYS);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] bits;
  logic [SET_W-1:0] scan_set;
  logic [WAY_W-1:0] scan_way;
  logic             clr_stb;
  logic             line_dirty;
  logic             wr_old;
  logic             wr_new;

  assign line_dirty  = bits[scan_set][scan_way];
  assign wr_old      = bits[bus.set_idx][bus.way_idx];
  assign wr_new      = bus.miss ? bus.dirty_d : (wr_old | bus.dirty_d);
  assign bus.dirty_q = bits[bus.set_idx];

  dirty_flush_scan #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .flush_req  (bus.flush_req),
    .line_dirty (line_dirty),
    .wb_ready   (bus.wb_ready),
    .flush_busy (bus.flush_busy),
    .flush_done (bus.flush_done),
    .wb_valid   (bus.wb_valid),
    .clr_stb    (clr_stb),
    .ptr_set    (scan_set),
    .ptr_way    (scan_way)
  );

  assign bus.wb_set = scan_set;
  assign bus.wb_way = scan_way;

  // Controller write is applied last so it overrides a same-line write-back clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      bits <= '0;
    end else begin
      if (clr_stb) begin
        bits[scan_set][scan_way] <= 1'b0;
      end
      if (bus.dirty_we) begin
        bits[bus.set_idx][bus.way_idx] <= wr_new;
      end
    end
  end

`ifdef DIRTY_COUNT_EN
  logic [CNT_W-1:0] count;
  logic             same_line;
  logic             inc;
  logic             dec_wr;
  logic             dec_wb;

  assign same_line = bus.dirty_we && (bus.set_idx == scan_set) && (bus.way_idx == scan_way);
  assign inc       = bus.dirty_we & ~wr_old & wr_new;
  assign dec_wr    = bus.dirty_we & wr_old & ~wr_new;
  assign dec_wb    = clr_stb & line_dirty & ~same_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(inc) - CNT_W'(dec_wr) - CNT_W'(dec_wb);
    end
  end

  assign bus.dirty_count = count;
`else
  assign bus.dirty_count = '0;
`endif

endmodule

// File: tb/tb_dirty_array_flush.sv
// Bench for dirty_array_flush: directed and random writes and flushes against a line-array model.
module tb_dirty_array_flush;
  localparam int NS = 8;
  localparam int NW = 4;
  localparam int NL = NS * NW;
  localparam int SET_W = $clog2(NS);
  localparam int WAY_W = $clog2(NW);

  typedef struct {
    int s;
    int w;
  } line_t;

  logic  clk;
  logic  reset;
  int    vectors = 0;
  int    miscompares = 0;
  bit    mdl [NS][NW];
  line_t wbq [$];

  dirty_array_flush_if #(.NUM_SETS(NS), .NUM_WAYS(NW)) bus ();

  dirty_array_flush #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] exp_q(input int s);
    logic [NW-1:0] v;
    for (int w = 0; w < NW; w++) v[w] = mdl[s][w];
    return v;
  endfunction

  function automatic int exp_cnt();
    int n = 0;
`ifdef DIRTY_COUNT_EN
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) n += int'(mdl[s][w]);
`endif
    return n;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) mdl[s][w] = 1'b0;
  endtask

  task automatic check_sets(input string tag);
    for (int s = 0; s < NS; s++) begin
      bus.set_idx = SET_W'(s);
      #1;
      chk(tag, 32'(bus.dirty_q), 32'(exp_q(s)));
    end
    chk({tag, "_count"}, 32'(bus.dirty_count), exp_cnt());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic wr(input int s, input int w, input bit m, input bit d);
    bus.set_idx  = SET_W'(s);
    bus.way_idx  = WAY_W'(w);
    bus.miss     = m;
    bus.dirty_d  = d;
    bus.dirty_we = 1'b1;
    tick();
    bus.dirty_we = 1'b0;
    mdl[s][w] = m ? d : (mdl[s][w] | d);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready only after 5 stalled cycles per line.
  task automatic run_flush(input int mode, input bit conflict, output int cycles);
    int    wbcyc;
    int    stall;
    bit    rdy;
    line_t ln;
    wbq.delete();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        if (mdl[s][w]) begin
          ln.s = s;
          ln.w = w;
          wbq.push_back(ln);
        end
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    cycles = 1;
    wbcyc  = 0;
    stall  = 0;
    while (!bus.flush_done && cycles < 2000) begin
      chk("busy_during_flush", 32'(bus.flush_busy), 32'd1);
      if (bus.wb_valid) begin
        wbcyc++;
        if (wbq.size() == 0) begin
          chk("wb_spurious", 32'(bus.wb_valid), 32'd0);
          bus.wb_ready = 1'b1;
        end else begin
          chk("wb_set", 32'(bus.wb_set), wbq[0].s);
          chk("wb_way", 32'(bus.wb_way), wbq[0].w);
          case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (stall >= 5);
          endcase
          stall = rdy ? 0 : stall + 1;
          bus.wb_ready = rdy;
          if (rdy) begin
            if (conflict && wbq[0].s == 6 && wbq[0].w == 3) begin
              bus.set_idx  = SET_W'(6);
              bus.way_idx  = WAY_W'(3);
              bus.miss     = 1'b0;
              bus.dirty_d  = 1'b1;
              bus.dirty_we = 1'b1;
              mdl[6][3]    = 1'b1;
            end else begin
              mdl[wbq[0].s][wbq[0].w] = 1'b0;
            end
            void'(wbq.pop_front());
          end
        end
      end else begin
        bus.wb_ready = 1'($urandom_range(0, 1));
      end
      tick();
      bus.wb_ready = 1'b0;
      bus.dirty_we = 1'b0;
      cycles++;
    end
    chk("done_pulse", 32'(bus.flush_done), 32'd1);
    chk("flush_latency", cycles, NL + 1 + wbcyc);
    chk("wb_all_issued", wbq.size(), 0);
    chk("busy_in_done", 32'(bus.flush_busy), 32'd1);
    tick();
    chk("done_one_cycle", 32'(bus.flush_done), 32'd0);
    chk("busy_after", 32'(bus.flush_busy), 32'd0);
    check_sets("after_flush");
  endtask

  initial begin
    int cyc;
    int n;
    reset         = 1'b1;
    bus.set_idx   = '0;
    bus.way_idx   = '0;
    bus.dirty_we  = 1'b0;
    bus.miss      = 1'b0;
    bus.dirty_d   = 1'b0;
    bus.flush_req = 1'b0;
    bus.wb_ready  = 1'b0;
    do_reset();

    chk("rst_busy", 32'(bus.flush_busy), 32'd0);
    chk("rst_done", 32'(bus.flush_done), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_set", 32'(bus.wb_set), 32'd0);
    chk("rst_wb_way", 32'(bus.wb_way), 32'd0);
    check_sets("rst_dirty_q");

    wr(3, 2, 1'b0, 1'b1);
    #1 chk("hit_set", 32'(bus.dirty_q), 32'(exp_q(3)));
    chk("hit_set_lit", 32'(bus.dirty_q), 32'h4);
    wr(3, 2, 1'b0, 1'b0);
    #1 chk("hit_no_clean", 32'(bus.dirty_q), 32'h4);
    wr(3, 2, 1'b1, 1'b0);
    #1 chk("fill_clean", 32'(bus.dirty_q), 32'h0);

    for (int i = 0; i < 60; i++) begin
      wr($urandom_range(0, NS - 1), $urandom_range(0, NW - 1),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1 chk("rand_dirty_q", 32'(bus.dirty_q), 32'(exp_q(int'(bus.set_idx))));
      chk("rand_count", 32'(bus.dirty_count), exp_cnt());
    end
    run_flush(1, 1'b0, cyc);

    do_reset();
    wr(1, 0, 1'b0, 1'b1);
    wr(6, 3, 1'b0, 1'b1);
    check_sets("two_dirty");
    run_flush(0, 1'b0, cyc);

    wr(1, 0, 1'b1, 1'b1);
    wr(6, 3, 1'b1, 1'b1);
    run_flush(2, 1'b0, cyc);

    run_flush(0, 1'b0, cyc);
    chk("empty_latency", cyc, 33);

    wr(1, 0, 1'b0, 1'b1);
    wr(6, 3, 1'b0, 1'b1);
    run_flush(0, 1'b1, cyc);
    bus.set_idx = SET_W'(6);
    #1 chk("conflict_keeps_dirty", 32'(bus.dirty_q), 32'h8);

    do_reset();
    wr(1, 0, 1'b0, 1'b1);
    wr(6, 3, 1'b0, 1'b1);
    bus.wb_ready  = 1'b0;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    n = 0;
    while (!bus.wb_valid && n < 100) begin
      tick();
      n++;
    end
    chk("reach_wb", 32'(bus.wb_valid), 32'd1);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    chk("busy_req_ignored", 32'(bus.wb_valid), 32'd1);
    chk("busy_req_set", 32'(bus.wb_set), 32'd1);
    chk("busy_req_way", 32'(bus.wb_way), 32'd0);
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(bus.flush_busy), 32'd0);
    chk("midrst_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst_done", 32'(bus.flush_done), 32'd0);
    reset = 1'b0;
    clear_model();
    check_sets("midrst_dirty_q");
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("midrst_no_done", 32'(bus.flush_done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
